// File: rtl/mem_wb_align_pkg.sv
// Shared widths, load funct3 encodings and FSM states for the load
// writeback alignment stage.
package mem_wb_align_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 40;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_LDU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_align_load_aligner.sv
// Combinational load data alignment: shift the doubleword down to the
// addressed byte, then sign- or zero-extend according to funct3.
module load_aligner
  import mem_wb_align_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        addr,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = data >> {addr, 3'b000};
    result  = shifted;
    case (funct3)
      F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   result = shifted;
      F3_LBU:  result = {56'd0, shifted[7:0]};
      F3_LHU:  result = {48'd0, shifted[15:0]};
      F3_LWU:  result = {32'd0, shifted[31:0]};
      F3_LDU:  result = shifted;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_wb_align.sv
// Captures an outstanding dcache load, aligns its response and holds it
// for writeback; handles nack replay, watchdog timeout and kill flushes.
module mem_wb_align
  import mem_wb_align_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_addr_i,
  input  logic [3:0]        req_op_type_i,
  input  logic [4:0]        req_rd_i,
  input  logic [ADDR_W-1:0] req_pc_i,
  input  logic              dmem_resp_valid_i,
  input  logic [DATA_W-1:0] dmem_resp_bits_data_i,
  input  logic              dmem_resp_bits_nack_i,
  input  logic              kill_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic [ADDR_W-1:0] wb_pc_o,
  output logic              replay_o,
  output logic              timeout_o
);

  // The counter holds the number of WAIT cycles already elapsed, so the
  // watchdog fires at the end of the TIMEOUT_CYCLES-th silent WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        addr_q, funct3_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] data_q, aligned;
  logic [7:0]        cnt_q;
  logic              replay_q, replay_d, timeout_q, timeout_d;
  logic              load_data, capture;
  logic              unused_op_class;

  // Bit 3 of the op type only classifies the op upstream; funct3 drives alignment.
  assign unused_op_class = req_op_type_i[3];

  assign req_ready_o = (state_q == S_IDLE) | ((state_q == S_HOLD) & wb_ready_i);
  assign capture     = req_valid_i & req_ready_o & ~kill_i;

  load_aligner u_aligner (
    .data   (dmem_resp_bits_data_i),
    .addr   (addr_q),
    .funct3 (funct3_q),
    .result (aligned)
  );

  always_comb begin
    state_d   = state_q;
    replay_d  = 1'b0;
    timeout_d = 1'b0;
    load_data = 1'b0;
    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (capture) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (dmem_resp_valid_i) begin
            state_d   = S_HOLD;
            load_data = 1'b1;
          end else if (dmem_resp_bits_nack_i) begin
            state_d  = S_IDLE;
            replay_d = 1'b1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (wb_ready_i) state_d = capture ? S_WAIT : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      replay_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      replay_q  <= replay_d;
      timeout_q <= timeout_d;
      cnt_q     <= (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + 8'd1 : '0;
      if (capture) begin
        addr_q   <= req_addr_i;
        funct3_q <= req_op_type_i[2:0];
        rd_q     <= req_rd_i;
        pc_q     <= req_pc_i;
      end
      if (load_data) data_q <= aligned;
    end
  end

  assign wb_valid_o = (state_q == S_HOLD);
  assign wb_data_o  = data_q;
  assign wb_rd_o    = rd_q;
  assign wb_pc_o    = pc_q;
  assign replay_o   = replay_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_mem_wb_align.sv
// Directed bench for mem_wb_align: table of alignment vectors plus
// hand-written sequences for hold, nack, timeout, kill and back-to-back.
module tb_mem_wb_align;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_addr_i;
  logic [3:0]  req_op_type_i;
  logic [4:0]  req_rd_i;
  logic [39:0] req_pc_i;
  logic        dmem_resp_valid_i;
  logic [63:0] dmem_resp_bits_data_i;
  logic        dmem_resp_bits_nack_i;
  logic        kill_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [39:0] wb_pc_o;
  logic        replay_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D       = 64'hF0E1_D2C3_B4A5_9687;
  localparam logic [39:0] PC_BASE = 40'h80_0000_0000;

  typedef struct {
    logic [2:0]  addr;
    logic [3:0]  op;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[16];

  mem_wb_align #(.TIMEOUT_CYCLES(255)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_addr_i            (req_addr_i),
    .req_op_type_i         (req_op_type_i),
    .req_rd_i              (req_rd_i),
    .req_pc_i              (req_pc_i),
    .dmem_resp_valid_i     (dmem_resp_valid_i),
    .dmem_resp_bits_data_i (dmem_resp_bits_data_i),
    .dmem_resp_bits_nack_i (dmem_resp_bits_nack_i),
    .kill_i                (kill_i),
    .wb_valid_o            (wb_valid_o),
    .wb_ready_i            (wb_ready_i),
    .wb_data_o             (wb_data_o),
    .wb_rd_o               (wb_rd_o),
    .wb_pc_o               (wb_pc_o),
    .replay_o              (replay_o),
    .timeout_o             (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [2:0] a, input logic [3:0] op,
                               input logic [4:0] rd, input logic [39:0] pc,
                               input logic respv, input logic [63:0] d,
                               input logic nk, input logic kl);
    req_valid_i           = rv;
    req_addr_i            = a;
    req_op_type_i         = op;
    req_rd_i              = rd;
    req_pc_i              = pc;
    dmem_resp_valid_i     = respv;
    dmem_resp_bits_data_i = d;
    dmem_resp_bits_nack_i = nk;
    kill_i                = kl;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int early;

    vecs[0]  = '{3'd0, 4'd0, D, 64'hFFFF_FFFF_FFFF_FF87};
    vecs[1]  = '{3'd0, 4'd4, D, 64'h0000_0000_0000_0087};
    vecs[2]  = '{3'd3, 4'd0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[3]  = '{3'd3, 4'd0, D, 64'hFFFF_FFFF_FFFF_FFB4};
    vecs[4]  = '{3'd7, 4'd0, D, 64'hFFFF_FFFF_FFFF_FFF0};
    vecs[5]  = '{3'd5, 4'd4, D, 64'h0000_0000_0000_00D2};
    vecs[6]  = '{3'd2, 4'd1, D, 64'hFFFF_FFFF_FFFF_B4A5};
    vecs[7]  = '{3'd6, 4'd5, D, 64'h0000_0000_0000_F0E1};
    vecs[8]  = '{3'd0, 4'd2, D, 64'hFFFF_FFFF_B4A5_9687};
    vecs[9]  = '{3'd4, 4'd6, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001};
    vecs[10] = '{3'd0, 4'd3, D, D};
    vecs[11] = '{3'd0, 4'd7, D, D};
    vecs[12] = '{3'd0, 4'd2, 64'h1234_5678_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
    vecs[13] = '{3'd0, 4'hA, D, 64'hFFFF_FFFF_B4A5_9687};
    vecs[14] = '{3'd4, 4'd2, D, 64'hFFFF_FFFF_F0E1_D2C3};
    vecs[15] = '{3'd0, 4'd5, D, 64'h0000_0000_0000_9687};

    // Reset state
    idleInputs();
    wb_ready_i = 1'b1;
    rst_i = 1'b1;
    tick();
    tick();
    checkOutput("reset_wb_valid", 64'(wb_valid_o), 64'd0);
    checkOutput("reset_replay", 64'(replay_o), 64'd0);
    checkOutput("reset_timeout", 64'(timeout_o), 64'd0);
    checkOutput("reset_wb_data", wb_data_o, 64'd0);
    checkOutput("reset_wb_rd", 64'(wb_rd_o), 64'd0);
    checkOutput("reset_wb_pc", 64'(wb_pc_o), 64'd0);
    checkOutput("reset_ready", 64'(req_ready_o), 64'd1);
    rst_i = 1'b0;
    tick();

    // Table of alignment vectors, each a full request/response/writeback
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].addr, vecs[i].op, 5'(i + 1), PC_BASE + 40'(i * 4),
                    1'b0, 64'd0, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_wait_valid", i), 64'(wb_valid_o), 64'd0);
      applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, vecs[i].data, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 64'(wb_valid_o), 64'd1);
      checkOutput($sformatf("vec%0d_data", i), wb_data_o, vecs[i].exp);
      checkOutput($sformatf("vec%0d_rd", i), 64'(wb_rd_o), 64'(i + 1));
      checkOutput($sformatf("vec%0d_pc", i), 64'(wb_pc_o), 64'(PC_BASE + 40'(i * 4)));
      idleInputs();
      tick();
      checkOutput($sformatf("vec%0d_release", i), 64'(wb_valid_o), 64'd0);
    end

    // LWU held under backpressure; stray request and response are ignored
    wb_ready_i = 1'b0;
    applyStimulus(1'b1, 3'd4, 4'd6, 5'd17, 40'h12_3456_7890, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, 64'h8000_0001_0000_0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd0, 4'd3, 5'd3, 40'h00_0000_0444, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold%0d_valid", k), 64'(wb_valid_o), 64'd1);
      checkOutput($sformatf("hold%0d_data", k), wb_data_o, 64'h0000_0000_8000_0001);
      checkOutput($sformatf("hold%0d_rd", k), 64'(wb_rd_o), 64'd17);
      checkOutput($sformatf("hold%0d_pc", k), 64'(wb_pc_o), 64'h12_3456_7890);
      checkOutput($sformatf("hold%0d_ready", k), 64'(req_ready_o), 64'd0);
      tick();
    end
    checkOutput("hold_no_replay", 64'(replay_o), 64'd0);
    idleInputs();
    wb_ready_i = 1'b1;
    tick();
    checkOutput("hold_release", 64'(wb_valid_o), 64'd0);

    // Nack in WAIT produces a single replay pulse and returns to IDLE
    applyStimulus(1'b1, 3'd0, 4'd2, 5'd4, 40'h100, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    checkOutput("nack_replay", 64'(replay_o), 64'd1);
    checkOutput("nack_ready", 64'(req_ready_o), 64'd1);
    checkOutput("nack_wb_valid", 64'(wb_valid_o), 64'd0);
    tick();
    checkOutput("nack_replay_drop", 64'(replay_o), 64'd0);
    idleInputs();
    tick();
    checkOutput("idle_nack_ignored", 64'(replay_o), 64'd0);

    // Response and nack together count as a valid response
    applyStimulus(1'b1, 3'd1, 4'd4, 5'd6, 40'h200, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, 64'h0000_0000_0000_AB00, 1'b1, 1'b0);
    tick();
    checkOutput("both_valid", 64'(wb_valid_o), 64'd1);
    checkOutput("both_data", wb_data_o, 64'h0000_0000_0000_00AB);
    checkOutput("both_no_replay", 64'(replay_o), 64'd0);
    idleInputs();
    tick();

    // Watchdog: 255 silent WAIT cycles then a one-cycle timeout pulse
    applyStimulus(1'b1, 3'd0, 4'd3, 5'd7, 40'h300, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("timeout_wait_ready", 64'(req_ready_o), 64'd0);
    early = 0;
    for (int k = 1; k < 255; k++) begin
      tick();
      if (timeout_o !== 1'b0 || wb_valid_o !== 1'b0 || req_ready_o !== 1'b0) early++;
    end
    checkOutput("timeout_quiet", 64'(early), 64'd0);
    tick();
    checkOutput("timeout_pulse", 64'(timeout_o), 64'd1);
    checkOutput("timeout_ready", 64'(req_ready_o), 64'd1);
    tick();
    checkOutput("timeout_pulse_end", 64'(timeout_o), 64'd0);

    // Kill beats a simultaneous response
    applyStimulus(1'b1, 3'd0, 4'd3, 5'd8, 40'h400, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, D, 1'b0, 1'b1);
    tick();
    checkOutput("kill_resp_valid", 64'(wb_valid_o), 64'd0);
    checkOutput("kill_resp_ready", 64'(req_ready_o), 64'd1);
    idleInputs();
    tick();
    checkOutput("kill_resp_after", 64'(wb_valid_o), 64'd0);

    // Kill beats a request capture in IDLE; the later response is dropped
    applyStimulus(1'b1, 3'd0, 4'd3, 5'd9, 40'h500, 1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    checkOutput("kill_req_ready", 64'(req_ready_o), 64'd1);
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, D, 1'b0, 1'b0);
    tick();
    checkOutput("kill_req_drop", 64'(wb_valid_o), 64'd0);

    // Kill while holding clears wb_valid
    wb_ready_i = 1'b0;
    applyStimulus(1'b1, 3'd0, 4'd3, 5'd10, 40'h600, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, D, 1'b0, 1'b0);
    tick();
    checkOutput("kill_hold_pre", 64'(wb_valid_o), 64'd1);
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    checkOutput("kill_hold_valid", 64'(wb_valid_o), 64'd0);
    idleInputs();
    wb_ready_i = 1'b1;
    tick();

    // Back-to-back: new request accepted in the HOLD cycle that drains
    applyStimulus(1'b1, 3'd0, 4'd2, 5'd5, 40'h0A_0000_0010, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, 64'h0000_0000_0000_1234, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd2, 4'd1, 5'd9, 40'h0B_0000_0020, 1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("b2b_first_rd", 64'(wb_rd_o), 64'd5);
    checkOutput("b2b_first_data", wb_data_o, 64'h0000_0000_0000_1234);
    checkOutput("b2b_hold_ready", 64'(req_ready_o), 64'd1);
    tick();
    checkOutput("b2b_wait_valid", 64'(wb_valid_o), 64'd0);
    checkOutput("b2b_wait_ready", 64'(req_ready_o), 64'd0);
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b1, 64'h0000_0000_7654_0000, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_second_valid", 64'(wb_valid_o), 64'd1);
    checkOutput("b2b_second_data", wb_data_o, 64'h0000_0000_0000_7654);
    checkOutput("b2b_second_rd", 64'(wb_rd_o), 64'd9);
    checkOutput("b2b_second_pc", 64'(wb_pc_o), 64'h0B_0000_0020);
    idleInputs();
    tick();

    // Reset mid-WAIT discards the transaction without replay
    applyStimulus(1'b1, 3'd0, 4'd3, 5'd11, 40'h700, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 5'd0, 40'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    rst_i = 1'b1;
    tick();
    checkOutput("rst_wait_replay", 64'(replay_o), 64'd0);
    checkOutput("rst_wait_ready", 64'(req_ready_o), 64'd1);
    checkOutput("rst_wait_rd", 64'(wb_rd_o), 64'd0);
    rst_i = 1'b0;
    idleInputs();
    tick();
    checkOutput("rst_wait_after", 64'(replay_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
